// File: rtl/gol_pkg.sv
// Shared Game-of-Life types: sequencer state, 3x3 window bit positions, torus index wrap.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Bit positions inside the 9-bit neighbourhood window, row-major from the north-west corner.
  localparam int NW     = 8;
  localparam int N      = 7;
  localparam int NE     = 6;
  localparam int W      = 5;
  localparam int CENTRE = 4;
  localparam int E      = 3;
  localparam int SW     = 2;
  localparam int S      = 1;
  localparam int SE     = 0;

  // Wrap any (possibly negative) index onto 0..n-1 so the board behaves as a torus.
  function automatic int wrap_idx(input int i, input int n);
    int m;
    m = i % n;
    if (m < 0) m = m + n;
    return m;
  endfunction

endpackage

// File: rtl/GOLNode.sv
// One Game-of-Life cell update: birth on 3 live neighbours, survival on 2 or 3.
// Latency: purely combinational.
// Backpressure: none; output follows the window every cycle.
module GOLNode
  import gol_pkg::*;
(
  input  logic [8:0] i_window,
  output logic       o_alive
);

  logic [3:0] w_cnt;

  // Count live neighbours, skipping the centre cell.
  always_comb begin
    w_cnt = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i != CENTRE) w_cnt = w_cnt + {3'b000, i_window[i]};
    end
  end

  assign o_alive = (w_cnt == 4'd3) || (i_window[CENTRE] && (w_cnt == 4'd2));

endmodule

// File: rtl/gol_generation_sequencer.sv
// Owns a toroidal board; advances it N generations, one cell per cycle through a shared GOLNode.
// Latency: N*(WIDTH*HEIGHT+1) cycles from accepted start to the done pulse.
// Backpressure: load_ready low while busy; loads and starts during a run are dropped, not queued.
module gol_generation_sequencer
  import gol_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [$clog2(HEIGHT)-1:0] load_row,
  input  logic [WIDTH-1:0]          load_data,
  input  logic                      start,
  input  logic [CNT_W-1:0]          step_count,
  input  logic                      stop,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          gen_count,
  output logic [WIDTH*HEIGHT-1:0]   board
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(CELLS);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CELLS-1:0]   r_board;
  logic [CELLS-1:0]   r_next;
  logic [CNT_W-1:0]   r_gen;
  logic [CNT_W-1:0]   r_remaining;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic               r_stop_pending;
  logic               r_done;

  logic [8:0]         w_window;
  logic               w_alive;
  logic [IDX_W-1:0]   w_idx;
  logic               w_last_cell;
  logic               w_load_ready;
  logic               w_busy;
  logic               w_run_ends;

  // Read one board cell with torus wrap on both axes.
  function automatic logic cell_at(input logic [CELLS-1:0] b, input int r, input int c);
    return b[IDX_W'(wrap_idx(r, HEIGHT) * WIDTH + wrap_idx(c, WIDTH))];
  endfunction

  assign w_idx       = IDX_W'(int'(r_row) * WIDTH + int'(r_col));
  assign w_last_cell = (r_row == ROW_W'(HEIGHT - 1)) && (r_col == COL_W'(WIDTH - 1));
  assign w_run_ends  = (r_remaining == CNT_W'(1)) || r_stop_pending;

  // Gather the 3x3 neighbourhood of the current cell from the committed board only.
  always_comb begin
    int r;
    int c;
    r = int'(r_row);
    c = int'(r_col);
    w_window         = '0;
    w_window[NW]     = cell_at(r_board, r - 1, c - 1);
    w_window[N]      = cell_at(r_board, r - 1, c);
    w_window[NE]     = cell_at(r_board, r - 1, c + 1);
    w_window[W]      = cell_at(r_board, r,     c - 1);
    w_window[CENTRE] = cell_at(r_board, r,     c);
    w_window[E]      = cell_at(r_board, r,     c + 1);
    w_window[SW]     = cell_at(r_board, r + 1, c - 1);
    w_window[S]      = cell_at(r_board, r + 1, c);
    w_window[SE]     = cell_at(r_board, r + 1, c + 1);
  end

  GOLNode u_node (
    .i_window (w_window),
    .o_alive  (w_alive)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_load_ready = 1'b1;
        if (start && (step_count != '0)) w_state_nxt = COMPUTE;
      end
      COMPUTE: begin
        w_busy = 1'b1;
        if (w_last_cell) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_busy      = 1'b1;
        w_state_nxt = w_run_ends ? IDLE : COMPUTE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Board, next buffer, counters and the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_board        <= '0;
      r_next         <= '0;
      r_gen          <= '0;
      r_remaining    <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_stop_pending <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_valid && w_load_ready && (int'(load_row) < HEIGHT)) begin
            r_board[IDX_W'(int'(load_row) * WIDTH) +: WIDTH] <= load_data;
            r_gen <= '0;
          end
          if (start) begin
            if (step_count != '0) begin
              r_remaining    <= step_count;
              r_row          <= '0;
              r_col          <= '0;
              r_stop_pending <= 1'b0;
            end else begin
              // A zero-length run still reports completion.
              r_done <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          r_next[w_idx] <= w_alive;
          if (stop) r_stop_pending <= 1'b1;
          if (w_last_cell) begin
            r_row <= '0;
            r_col <= '0;
          end else if (r_col == COL_W'(WIDTH - 1)) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
        COMMIT: begin
          r_board     <= r_next;
          r_gen       <= r_gen + CNT_W'(1);
          r_remaining <= r_remaining - CNT_W'(1);
          if (stop) r_stop_pending <= 1'b1;
          if (w_run_ends) r_done <= 1'b1;
          r_row <= '0;
          r_col <= '0;
        end
        default: ;
      endcase
    end
  end

  assign load_ready = w_load_ready;
  assign busy       = w_busy;
  assign done       = r_done;
  assign gen_count  = r_gen;
  assign board      = r_board;

endmodule

// File: tb/tb_gol_generation_sequencer.sv
module tb_gol_generation_sequencer;
  import gol_pkg::*;

  localparam int WD  = 8;
  localparam int HT  = 8;
  localparam int CW  = 16;
  localparam int GEN_CYC = WD * HT + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [2:0]    load_row = '0;
  logic [7:0]    load_data = '0;
  logic          start = 1'b0;
  logic [CW-1:0] step_count = '0;
  logic          stop = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] gen_count;
  logic [63:0]   board;

  typedef struct {
    logic [63:0]   board;
    logic [CW-1:0] gen;
    int            cycles;
  } exp_t;

  exp_t          sb[$];
  logic [63:0]   model_board = '0;
  logic [CW-1:0] model_gen = '0;
  int            checks = 0;
  int            failures = 0;

  gol_generation_sequencer #(.WIDTH(WD), .HEIGHT(HT), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_row   (load_row),
    .load_data  (load_data),
    .start      (start),
    .step_count (step_count),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .gen_count  (gen_count),
    .board      (board)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference Game-of-Life step: count the eight torus neighbours of every cell.
  function automatic logic [63:0] next_gen(input logic [63:0] b);
    logic [63:0] nb;
    nb = '0;
    for (int r = 0; r < HT; r++) begin
      for (int c = 0; c < WD; c++) begin
        int n;
        logic alive;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              n += int'(b[6'(wrap_idx(r + dr, HT) * WD + wrap_idx(c + dc, WD))]);
          end
        end
        alive = b[6'(r * WD + c)];
        nb[6'(r * WD + c)] = (n == 3) || (alive && n == 2);
      end
    end
    return nb;
  endfunction

  task automatic load_one(input int row, input logic [7:0] data);
    load_valid = 1'b1;
    load_row   = 3'(row);
    load_data  = data;
    @(posedge clk); #1;
    load_valid = 1'b0;
    model_board[6'(row * WD) +: 8] = data;
    model_gen = '0;
  endtask

  task automatic load_board(input logic [63:0] b);
    for (int r = 0; r < HT; r++) load_one(r, b[6'(r * WD) +: 8]);
  endtask

  // Start a run, push its expected outcome, then watch the DUT until done (or abort on reset).
  task automatic run(input int steps, input int stop_at, input int load_at, input int reset_at);
    exp_t        e;
    exp_t        got;
    int          gens;
    int          cyc;
    int          busy_cnt;
    int          done_cnt;
    bit          aborted;
    logic [63:0] snap;
    gens = (stop_at >= 0) ? 1 : steps;
    e.board = model_board;
    for (int g = 0; g < gens; g++) e.board = next_gen(e.board);
    e.gen    = model_gen + CW'(gens);
    e.cycles = gens * GEN_CYC;
    sb.push_back(e);

    step_count = CW'(steps);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    aborted = 1'b0;
    snap = board;
    while (!done && cyc < 2000) begin
      stop = (cyc == stop_at);
      if (cyc == load_at) begin
        load_valid = 1'b1;
        load_row   = 3'd0;
        load_data  = 8'hFF;
        snap = board;
        check("load_ready_while_busy", 64'(load_ready), 64'd0);
      end
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_board", board, 64'd0);
        check("abort_gen", 64'(gen_count), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_load_ready", 64'(load_ready), 64'd1);
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      load_valid = 1'b0;
      if (cyc == load_at + 1) check("board_stable_busy", board, snap);
      if (busy) busy_cnt++;
    end
    stop = 1'b0;

    if (aborted) begin
      sb.delete();
      #3 rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 2 * GEN_CYC; i++) begin
        @(posedge clk); #1;
        if (done) done_cnt++;
      end
      check("no_done_after_abort", 64'(done_cnt), 64'd0);
      model_board = '0;
      model_gen = '0;
    end else begin
      got = sb.pop_front();
      model_board = got.board;
      model_gen   = got.gen;
      check("done_latency", 64'(cyc), 64'(got.cycles));
      check("busy_cycles", 64'(busy_cnt), 64'(got.cycles));
      check("board", board, got.board);
      check("gen_count", 64'(gen_count), 64'(got.gen));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_board", board, 64'd0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Horizontal blinker becomes vertical at column 3.
    load_one(3, 8'b00011100);
    run(1, -1, -1, -1);
    check("blinker_cells", board, 64'h0000_0008_0808_0000);

    // Block still life over five generations.
    load_board(64'h0000_0000_0006_0600);
    run(5, -1, -1, -1);
    check("block_unchanged", board, 64'h0000_0000_0006_0600);

    // Vertical blinker on column 0 flips across the column wrap.
    load_board(64'h0000_0101_0100_0000);
    run(1, -1, -1, -1);
    check("wrap_blinker", board, 64'h0000_0083_0000_0000);

    // Glider with stop requested mid-way through the first generation.
    load_board(64'h0000_0000_0007_0402);
    run(10, 20, -1, -1);

    // Load attempted while computing is ignored.
    run(1, -1, 10, -1);

    // Zero-step start only pulses done.
    run(0, -1, -1, -1);

    // Reset in the middle of a run aborts it cleanly.
    run(3, -1, -1, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gol_generation_sequencer.md
Name: gol_generation_sequencer

Overview:
Owns a toroidal Game-of-Life board and advances it one or more generations on command. It time-multiplexes a single shared GOLNode instance, evaluating one cell per clock into a next-state buffer, then commits the whole buffer at once. It sits between the host/load logic and the display readout, which consumes the `board` output.

Parameters:
WIDTH, 8, board columns (at least 3)
HEIGHT, 8, board rows (at least 3)
CNT_W, 16, width of the step counter and generation counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_valid  in  1  row-write request
load_ready  out  1  high only in IDLE; a load is accepted on an edge where load_valid && load_ready
load_row  in  $clog2(HEIGHT)  row index to write
load_data  in  WIDTH  row contents; bit c = column c
start  in  1  run request; sampled only in IDLE
step_count  in  CNT_W  number of generations to run, latched when start is accepted
stop  in  1  request to end after the current generation; sticky once seen while busy
busy  out  1  high in COMPUTE and COMMIT
done  out  1  one-cycle pulse on return to IDLE after a run
gen_count  out  CNT_W  generations committed since the last accepted load
board  out  WIDTH*HEIGHT  current board; bit r*WIDTH+c = cell (r,c)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; board, next buffer, gen_count, remaining, cell index and stop_pending all 0.
  - busy=0, done=0, load_ready=1.
  - A reset asserted mid-run aborts the run. No done pulse is produced.
- GOLNode input window for cell (r,c) is a 9-bit value:
  - bit8=(r-1,c-1), bit7=(r-1,c), bit6=(r-1,c+1), bit5=(r,c-1), bit4=(r,c) centre, bit3=(r,c+1), bit2=(r+1,c-1), bit1=(r+1,c), bit0=(r+1,c+1).
  - Row and column indices wrap modulo HEIGHT and WIDTH (torus).
  - The window is always taken from `board`, never from the next buffer.
- FSM states: IDLE, COMPUTE, COMMIT.
- IDLE:
  - An accepted load writes board row load_row and clears gen_count to 0.
  - If start=1 and step_count!=0: latch remaining=step_count, set idx=0, clear stop_pending, go to COMPUTE.
  - If start=1 and step_count==0: stay in IDLE and pulse done on the next cycle. Board and gen_count are unchanged.
  - Load and start on the same edge: both take effect, and the first generation sees the loaded row.
- COMPUTE (one cell per cycle, row-major order):
  - Each edge writes next[idx] = GOLNode(window(idx)), then idx++.
  - After the edge that writes idx = WIDTH*HEIGHT-1, go to COMMIT.
- COMMIT (one cycle):
  - At the edge: board <= next, gen_count++ (wraps modulo 2^CNT_W), remaining--.
  - If remaining becomes 0 or stop_pending=1: go to IDLE and drive done=1 for exactly the following cycle.
  - Otherwise: set idx=0 and return to COMPUTE.
- Latency:
  - One generation = WIDTH*HEIGHT+1 cycles after start is accepted (65 for 8x8).
  - N generations = N*(WIDTH*HEIGHT+1) cycles.
  - done is high in the first IDLE cycle.
- stop:
  - Sampled high in COMPUTE or COMMIT: sets stop_pending. The current generation always completes and commits.
  - Ignored in IDLE.
- load_valid while busy is ignored (load_ready=0). Board is unchanged and nothing is queued.
- start while busy is ignored.
- `board` changes only on accepted loads and on COMMIT edges, so it is stable throughout COMPUTE.

Decomposition:
- Shared package gol_pkg holds:
  - the state enum typedef {IDLE, COMPUTE, COMMIT};
  - the window-bit index constants (NW..SE, CENTRE=4);
  - a wrap-index function used by both this block and the bench's reference model.
- Sub-module: exactly one instance of the existing GOLNode (combinational). No new sub-module is needed.
- Window gather and next buffer are local logic.

Test Plan:
- Blinker, horizontal:
  - Stimulus: load row 3 = 8'b00011100, start with step_count=1.
  - Response: busy for 65 cycles, then done pulse. Board has cells (2,3),(3,3),(4,3) set and nothing else. gen_count=1.
- Block still life:
  - Stimulus: cells (1,1),(1,2),(2,1),(2,2); start with step_count=5.
  - Response: done at cycle 325, board unchanged, gen_count=5.
- Wrap-around blinker:
  - Stimulus: vertical at column 0, rows 3-5; step_count=1.
  - Response: row 4 = 8'b10000011 (columns 7,0,1), all other rows 0.
- Stop mid-run:
  - Stimulus: step_count=10; pulse stop at cycle 20.
  - Response: done at cycle 65, gen_count=1, board equals generation 1.
- Reset mid-COMPUTE, then load while busy:
  - Stimulus: drop reset at cycle 30 of a run; separately, drive load_valid during COMPUTE.
  - Response: after reset, board=0, gen_count=0, busy=0, no done. During COMPUTE, load_ready=0 and board is unchanged until COMMIT.
- Zero-step start:
  - Stimulus: step_count=0 with start.
  - Response: busy stays 0, done pulses the next cycle, board and gen_count unchanged.
